// File: rtl/alarm_pkg.sv
// Shared state encodings, display codes and a sizing helper for alarm_controller.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_EXIT     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_ENTRY    = 3'd3,
    ST_ALARM    = 3'd4,
    ST_SILENCED = 3'd5
  } state_e;

  localparam logic [3:0] DIG_OFF   = 4'h0;
  localparam logic [3:0] DIG_EXIT  = 4'hE;
  localparam logic [3:0] DIG_ARMED = 4'hA;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/alarm_sync2.sv
// Parametrised-width two-flop synchroniser with asynchronous active-high reset.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/alarm_controller.sv
// Home alarm FSM: exit/entry delays, timed siren, zone latch and status digit.
// Optional door chime in DISARMED is built when ALARM_CHIME_EN is defined.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int N_SENSORS    = 4,
  parameter int EXIT_DELAY   = 8,
  parameter int ENTRY_DELAY  = 4,
  parameter int SIREN_CYCLES = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               arm,
  input  logic [N_SENSORS-1:0]               sensor,
  output logic                               alarm,
  output logic [2:0]                         state,
  output logic [$clog2(N_SENSORS+1)-1:0]     trip_count,
  output logic [3:0]                         digit
`ifdef ALARM_CHIME_EN
  ,
  output logic                               chime
`endif
);

  localparam int CW   = $clog2(N_SENSORS + 1);
  localparam int TMAX = max3(EXIT_DELAY, ENTRY_DELAY, SIREN_CYCLES);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] EXIT_LOAD  = TW'(EXIT_DELAY - 1);
  localparam logic [TW-1:0] ENTRY_LOAD = TW'(ENTRY_DELAY - 1);
  localparam logic [TW-1:0] SIREN_LOAD = TW'(SIREN_CYCLES - 1);

  logic [N_SENSORS-1:0] s_sync;
  logic                 arm_s;

  sync2 #(.W(N_SENSORS)) u_sync_sensor (
    .clk   (clk),
    .reset (reset),
    .d_i   (sensor),
    .q_o   (s_sync)
  );

  sync2 #(.W(1)) u_sync_arm (
    .clk   (clk),
    .reset (reset),
    .d_i   (arm),
    .q_o   (arm_s)
  );

  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [N_SENSORS-1:0] latch_q, latch_d;
  logic [CW-1:0]        trip_cnt_q, trip_cnt_d;
  logic [3:0]           digit_q, digit_d;
  logic [CW-1:0]        pop;
  logic                 trip;
  logic                 new_zone;
  logic                 timer_zero;

  assign trip       = |s_sync;
  assign new_zone   = |(s_sync & ~latch_q);
  assign timer_zero = (timer_q == '0);

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_SENSORS; i++) pop = pop + CW'(latch_q[i]);
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    latch_d    = latch_q;
    trip_cnt_d = pop;

    if (state_q inside {ST_ARMED, ST_ENTRY, ST_ALARM, ST_SILENCED})
      latch_d = latch_q | s_sync;

    case (state_q)
      ST_DISARMED: begin
        if (arm_s) begin
          state_d    = ST_EXIT;
          timer_d    = EXIT_LOAD;
          latch_d    = '0;
          trip_cnt_d = '0;
        end
      end
      ST_EXIT: begin
        if (timer_zero) state_d = ST_ARMED;
        else            timer_d = timer_q - 1'b1;
      end
      ST_ARMED: begin
        if (trip) begin
          state_d = ST_ENTRY;
          timer_d = ENTRY_LOAD;
        end
      end
      ST_ENTRY: begin
        // A closing sensor does not cancel the countdown; only disarm does.
        if (timer_zero) begin
          state_d = ST_ALARM;
          timer_d = SIREN_LOAD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_ALARM: begin
        if (timer_zero) state_d = ST_SILENCED;
        else            timer_d = timer_q - 1'b1;
      end
      ST_SILENCED: begin
        if (new_zone) begin
          state_d = ST_ALARM;
          timer_d = SIREN_LOAD;
        end
      end
      default: state_d = ST_DISARMED;
    endcase

    // Disarm wins over every other transition; the zone memory is kept.
    if (!arm_s) begin
      state_d = ST_DISARMED;
      timer_d = '0;
    end
  end

  // Digit follows the next state so it changes on the same edge as state.
  always_comb begin
    digit_d = DIG_OFF;
    case (state_d)
      ST_DISARMED: digit_d = (trip_cnt_d == '0) ? DIG_OFF : 4'(trip_cnt_d);
      ST_EXIT:     digit_d = DIG_EXIT;
      ST_ARMED:    digit_d = DIG_ARMED;
      default:     digit_d = 4'(trip_cnt_d);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_DISARMED;
      timer_q    <= '0;
      latch_q    <= '0;
      trip_cnt_q <= '0;
      digit_q    <= DIG_OFF;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      latch_q    <= latch_d;
      trip_cnt_q <= trip_cnt_d;
      digit_q    <= digit_d;
    end
  end

  assign alarm      = (state_q == ST_ALARM);
  assign state      = state_q;
  assign trip_count = trip_cnt_q;
  assign digit      = digit_q;

`ifdef ALARM_CHIME_EN
  logic [N_SENSORS-1:0] s_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) s_prev_q <= '0;
    else       s_prev_q <= s_sync;
  end

  assign chime = (state_q == ST_DISARMED) && |(s_sync & ~s_prev_q);
`endif

endmodule

// File: tb/tb_alarm_controller.sv
// Scoreboard bench for alarm_controller: per-cycle expected outputs are queued
// with the stimulus that produces them, then popped and compared each cycle.
module tb_alarm_controller;

  logic       clk;
  logic       reset;
  logic       arm;
  logic [3:0] sensor;
  logic       alarm;
  logic [2:0] state;
  logic [2:0] trip_count;
  logic [3:0] digit;
`ifdef ALARM_CHIME_EN
  logic       chime;
`endif

  int checks = 0;
  int errors = 0;

  alarm_controller dut (
    .clk        (clk),
    .reset      (reset),
    .arm        (arm),
    .sensor     (sensor),
    .alarm      (alarm),
    .state      (state),
    .trip_count (trip_count),
    .digit      (digit)
`ifdef ALARM_CHIME_EN
    ,
    .chime      (chime)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic       al;
    logic [3:0] dg;
    logic [2:0] tc;
    logic       arm;
    logic [3:0] sens;
  } exp_t;

  exp_t sb[$];

  // Queue n cycles of expected outputs together with the inputs held for them.
  function automatic void push(input logic [2:0] st, input logic al, input logic [3:0] dg,
                               input logic [2:0] tc, input logic a, input logic [3:0] s,
                               input int n);
    exp_t e;
    e.st = st; e.al = al; e.dg = dg; e.tc = tc; e.arm = a; e.sens = s;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; arm = 1'b0; sensor = 4'h0;
    #1;
    checks++;
    if ({state, alarm, digit, trip_count} !== {3'd0, 1'b0, 4'h0, 3'd0}) begin
      errors++;
      $display("FAIL reset_init: got st=%0d al=%0b dg=%h tc=%0d, want 0/0/0/0",
               state, alarm, digit, trip_count);
    end
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_arm_no_sensor();
    exp_t e;
    int t = 1;
    push(3'd0, 1'b0, 4'h0, 3'd0, 1'b1, 4'h0, 2);
    push(3'd1, 1'b0, 4'hE, 3'd0, 1'b1, 4'h0, 8);
    push(3'd2, 1'b0, 4'hA, 3'd0, 1'b1, 4'h0, 3);
    push(3'd2, 1'b0, 4'hA, 3'd0, 1'b0, 4'h0, 2);
    push(3'd0, 1'b0, 4'h0, 3'd0, 1'b0, 4'h0, 2);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      arm = e.arm; sensor = e.sens;
      tick();
      checks++;
      if ({state, alarm, digit, trip_count} !== {e.st, e.al, e.dg, e.tc}) begin
        errors++;
        $display("FAIL arm_no_sensor cyc %0d: got st=%0d al=%0b dg=%h tc=%0d, want st=%0d al=%0b dg=%h tc=%0d",
                 t, state, alarm, digit, trip_count, e.st, e.al, e.dg, e.tc);
      end
      t++;
    end
  endtask

  task automatic test_exit_mask_and_reset();
    exp_t e;
    int t = 1;
    push(3'd0, 1'b0, 4'h0, 3'd0, 1'b1, 4'h1, 2);
    push(3'd1, 1'b0, 4'hE, 3'd0, 1'b1, 4'h1, 8);
    push(3'd2, 1'b0, 4'hA, 3'd0, 1'b1, 4'h1, 1);
    push(3'd3, 1'b0, 4'h0, 3'd0, 1'b1, 4'h1, 1);
    push(3'd3, 1'b0, 4'h1, 3'd1, 1'b1, 4'h1, 3);
    push(3'd4, 1'b1, 4'h1, 3'd1, 1'b1, 4'h1, 2);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      arm = e.arm; sensor = e.sens;
      tick();
      checks++;
      if ({state, alarm, digit, trip_count} !== {e.st, e.al, e.dg, e.tc}) begin
        errors++;
        $display("FAIL exit_mask cyc %0d: got st=%0d al=%0b dg=%h tc=%0d, want st=%0d al=%0b dg=%h tc=%0d",
                 t, state, alarm, digit, trip_count, e.st, e.al, e.dg, e.tc);
      end
      t++;
    end
    // Asynchronous reset in the middle of ALARM, checked before any edge.
    #2;
    reset = 1'b1; arm = 1'b0; sensor = 4'h0;
    #1;
    checks++;
    if ({state, alarm, digit, trip_count} !== {3'd0, 1'b0, 4'h0, 3'd0}) begin
      errors++;
      $display("FAIL reset_mid_alarm: got st=%0d al=%0b dg=%h tc=%0d, want 0/0/0/0",
               state, alarm, digit, trip_count);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_alarm_silence_retrigger();
    exp_t e;
    int t = 1;
    push(3'd0, 1'b0, 4'h0, 3'd0, 1'b1, 4'h0, 2);
    push(3'd1, 1'b0, 4'hE, 3'd0, 1'b1, 4'h0, 8);
    push(3'd2, 1'b0, 4'hA, 3'd0, 1'b1, 4'h0, 1);
    push(3'd2, 1'b0, 4'hA, 3'd0, 1'b1, 4'h4, 2);
    push(3'd3, 1'b0, 4'h0, 3'd0, 1'b1, 4'h4, 1);
    push(3'd3, 1'b0, 4'h1, 3'd1, 1'b1, 4'h4, 3);
    push(3'd4, 1'b1, 4'h1, 3'd1, 1'b1, 4'h4, 16);
    push(3'd5, 1'b0, 4'h1, 3'd1, 1'b1, 4'h4, 1);
    push(3'd5, 1'b0, 4'h1, 3'd1, 1'b1, 4'h6, 2);
    push(3'd4, 1'b1, 4'h1, 3'd1, 1'b1, 4'h6, 1);
    push(3'd4, 1'b1, 4'h2, 3'd2, 1'b1, 4'h6, 15);
    push(3'd5, 1'b0, 4'h2, 3'd2, 1'b1, 4'h6, 1);
    push(3'd5, 1'b0, 4'h2, 3'd2, 1'b0, 4'h0, 2);
    push(3'd0, 1'b0, 4'h2, 3'd2, 1'b0, 4'h0, 2);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      arm = e.arm; sensor = e.sens;
      tick();
      checks++;
      if ({state, alarm, digit, trip_count} !== {e.st, e.al, e.dg, e.tc}) begin
        errors++;
        $display("FAIL alarm_silence cyc %0d: got st=%0d al=%0b dg=%h tc=%0d, want st=%0d al=%0b dg=%h tc=%0d",
                 t, state, alarm, digit, trip_count, e.st, e.al, e.dg, e.tc);
      end
      t++;
    end
  endtask

  task automatic test_disarm_entry();
    exp_t e;
    int t = 1;
    push(3'd0, 1'b0, 4'h2, 3'd2, 1'b1, 4'h0, 2);
    push(3'd1, 1'b0, 4'hE, 3'd0, 1'b1, 4'h0, 8);
    push(3'd2, 1'b0, 4'hA, 3'd0, 1'b1, 4'h0, 1);
    push(3'd2, 1'b0, 4'hA, 3'd0, 1'b1, 4'h1, 2);
    push(3'd3, 1'b0, 4'h0, 3'd0, 1'b1, 4'h1, 1);
    push(3'd3, 1'b0, 4'h1, 3'd1, 1'b0, 4'h1, 2);
    push(3'd0, 1'b0, 4'h1, 3'd1, 1'b0, 4'h1, 1);
    push(3'd0, 1'b0, 4'h1, 3'd1, 1'b0, 4'h0, 3);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      arm = e.arm; sensor = e.sens;
      tick();
      checks++;
      if ({state, alarm, digit, trip_count} !== {e.st, e.al, e.dg, e.tc}) begin
        errors++;
        $display("FAIL disarm_entry cyc %0d: got st=%0d al=%0b dg=%h tc=%0d, want st=%0d al=%0b dg=%h tc=%0d",
                 t, state, alarm, digit, trip_count, e.st, e.al, e.dg, e.tc);
      end
      t++;
    end
  endtask

`ifdef ALARM_CHIME_EN
  task automatic test_chime();
    logic exp_ch;
    arm = 1'b0;
    sensor = 4'h8;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_ch = (k == 2);
      checks++;
      if ({chime, state, alarm, digit, trip_count} !== {exp_ch, 3'd0, 1'b0, 4'h1, 3'd1}) begin
        errors++;
        $display("FAIL chime cyc %0d: got ch=%0b st=%0d al=%0b dg=%h tc=%0d, want ch=%0b st=0 al=0 dg=1 tc=1",
                 k, chime, state, alarm, digit, trip_count, exp_ch);
      end
    end
    sensor = 4'h0;
    tick(); tick(); tick();
  endtask
`endif

  initial begin
    test_reset();
    test_arm_no_sensor();
    test_exit_mask_and_reset();
    test_alarm_silence_retrigger();
    test_disarm_entry();
`ifdef ALARM_CHIME_EN
    test_chime();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
